// File: rtl/sample_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_scheduler_if
// Description : Control/status bundle between an acquisition controller and
//               the sample scheduler.
//               start/stop      - run request / abort level
//               div_half        - half sample period in clk cycles
//               num_samples     - samples per run
//               sample_ack      - acknowledge from the capture path
//               flag            - run-enable to the frequency divider
//               sample_req      - one-cycle strobe per sample period
//               busy/done       - run status / completion pulse
//               overrun         - sticky unacknowledged-request error
//               sample_cnt      - sample_req pulses in current/last run
//               Modport slave is the scheduler side, master the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_scheduler_if;
    logic       start;
    logic       stop;
    logic [7:0] div_half;
    logic [7:0] num_samples;
    logic       sample_ack;
    logic       flag;
    logic       sample_req;
    logic       busy;
    logic       done;
    logic       overrun;
    logic [7:0] sample_cnt;

    modport slave (
        input  start, stop, div_half, num_samples, sample_ack,
        output flag, sample_req, busy, done, overrun, sample_cnt
    );

    modport master (
        output start, stop, div_half, num_samples, sample_ack,
        input  flag, sample_req, busy, done, overrun, sample_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sample_scheduler
// Description : Acquisition-run scheduler. On an accepted start it enables
//               the frequency divider (flag), issues one sample_req every
//               2*div_half clk cycles until num_samples requests have been
//               made, waits for the last request to be acknowledged and
//               then pulses done. Tracks unacknowledged requests (overrun).
// Ports       : clk, rst (synchronous, active-high)
//               bus : sample_scheduler_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module sample_scheduler (
    input  wire logic           clk,
    input  wire logic           rst,
    sample_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] div_half_q;
    logic [7:0] num_samples_q;
    logic [7:0] sample_cnt_q;
    logic [8:0] period_cnt;
    logic [8:0] period_last;
    logic       pending;
    logic       overrun_q;

    logic       start_ok;
    logic       req;
    logic       last_sample;
    logic       abort;

    // 2*div_half - 1 in 9 bits; div_half is never 0 once a run is accepted.
    assign period_last = {div_half_q, 1'b0} - 9'd1;

    assign start_ok = (state == S_IDLE) && bus.start && !bus.stop &&
                      (bus.div_half != 8'd0) && (bus.num_samples != 8'd0);

    // stop overrides everything in RUN, including the sample strobe, so that
    // an aborted run leaves sample_cnt exactly as it was.
    assign req = (state == S_RUN) && !bus.stop && (period_cnt == period_last);

    assign last_sample = req && ((sample_cnt_q + 8'd1) == num_samples_q);

    assign abort = bus.stop && ((state == S_RUN) || (state == S_DRAIN));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.stop)         state_nxt = S_IDLE;
                else if (last_sample) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // An ack arriving this cycle already clears the last request.
                if (bus.stop)                         state_nxt = S_IDLE;
                else if (!pending || bus.sample_ack)  state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            div_half_q    <= 8'd0;
            num_samples_q <= 8'd0;
            sample_cnt_q  <= 8'd0;
            period_cnt    <= 9'd0;
            pending       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start_ok) begin
                div_half_q    <= bus.div_half;
                num_samples_q <= bus.num_samples;
                sample_cnt_q  <= 8'd0;
                period_cnt    <= 9'd0;
                pending       <= 1'b0;
                overrun_q     <= 1'b0;
            end else begin
                if ((state == S_RUN) && !bus.stop) begin
                    period_cnt <= (period_cnt == period_last) ? 9'd0
                                                              : period_cnt + 9'd1;
                end

                if (req && (sample_cnt_q != num_samples_q)) begin
                    sample_cnt_q <= sample_cnt_q + 8'd1;
                end

                if (req && pending && !bus.sample_ack) begin
                    overrun_q <= 1'b1;
                end

                // Same-cycle ack retires the old request; the new one stays.
                if (abort) begin
                    pending <= 1'b0;
                end else begin
                    pending <= req | (pending & ~bus.sample_ack);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.flag       = (state == S_RUN);
    assign bus.busy       = (state == S_RUN) || (state == S_DRAIN);
    assign bus.done       = (state == S_DONE);
    assign bus.sample_req = req;
    assign bus.overrun    = overrun_q;
    assign bus.sample_cnt = sample_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_scheduler
// Description : Directed self-checking bench for sample_scheduler. Inputs are
//               driven on the falling edge; outputs are sampled 1 time unit
//               later. RUN cycle 1 is the first cycle after start is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_scheduler;

    logic clk;
    logic rst;

    sample_scheduler_if bus ();

    sample_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #125 clk = ~clk;

    int n_checks;
    int n_errors;

    // Observations gathered by run_case
    int n_req;
    int req_at [1:8];
    int flag_cycles;
    int done_cyc;
    int stop_cyc;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode: 0 = ack coincident with each req (and in DRAIN),
    //       1 = ack one cycle after each req, 2 = never ack.
    // stop_after: assert stop in the cycle after this many reqs (0 = never).
    // hold: keep start high while flag is high.
    task automatic run_case(input int dh, input int ns, input int mode,
                            input int stop_after, input int hold,
                            input int max_cyc);
        logic ack_next;
        logic stop_next;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.div_half    = dh[7:0];
        bus.num_samples = ns[7:0];
        bus.sample_ack  = 1'b0;
        bus.stop        = 1'b0;
        @(negedge clk);
        if (hold == 0) bus.start = 1'b0;
        n_req = 0; flag_cycles = 0; done_cyc = 0; stop_cyc = 0;
        for (int i = 1; i <= 8; i++) req_at[i] = 0;
        ack_next  = 1'b0;
        stop_next = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            bus.sample_ack = ack_next;
            ack_next       = 1'b0;
            bus.stop       = stop_next;
            stop_next      = 1'b0;
            #1;
            if (!bus.flag) bus.start = 1'b0;
            if (bus.flag) flag_cycles++;
            if (bus.sample_req) begin
                n_req++;
                if (n_req <= 8) req_at[n_req] = cyc;
                if (mode == 0)      bus.sample_ack = 1'b1;
                else if (mode == 1) ack_next = 1'b1;
                if (n_req == stop_after) stop_next = 1'b1;
            end
            if (mode == 0 && bus.busy && !bus.flag) bus.sample_ack = 1'b1;
            if (bus.stop) stop_cyc = cyc;
            if (bus.done) done_cyc = cyc;
            if (bus.done || (stop_cyc != 0 && cyc == stop_cyc + 1)) break;
            @(negedge clk);
        end
        bus.sample_ack = 1'b0;
        bus.stop       = 1'b0;
        bus.start      = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.div_half    = 8'd0;
        bus.num_samples = 8'd0;
        bus.sample_ack  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_flag",    int'(bus.flag), 0);
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_done",    int'(bus.done), 0);
        check("rst_req",     int'(bus.sample_req), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_cnt",     int'(bus.sample_cnt), 0);
        rst = 1'b0;

        // dh=2, ns=3, ack one cycle late: reqs at 4,8,12; DRAIN 13; DONE 14
        run_case(2, 3, 1, 0, 0, 40);
        check("a_nreq",   n_req, 3);
        check("a_req1",   req_at[1], 4);
        check("a_req2",   req_at[2], 8);
        check("a_req3",   req_at[3], 12);
        check("a_flag",   flag_cycles, 12);
        check("a_done",   done_cyc, 14);
        check("a_cnt",    int'(bus.sample_cnt), 3);
        check("a_ovr",    int'(bus.overrun), 0);

        // Started in the IDLE cycle right after DONE; start held during RUN.
        // dh=1, ns=4, coincident acks: reqs 2,4,6,8; DRAIN 9 (acked); DONE 10
        run_case(1, 4, 0, 0, 1, 40);
        check("e_nreq",   n_req, 4);
        check("e_req1",   req_at[1], 2);
        check("e_req4",   req_at[4], 8);
        check("e_flag",   flag_cycles, 8);
        check("e_done",   done_cyc, 10);
        check("e_ovr",    int'(bus.overrun), 0);
        check("e_cnt",    int'(bus.sample_cnt), 4);
        @(negedge clk); #1;
        check("e_idle",   int'(bus.busy), 0);

        // dh=1, ns=2, no ack: reqs 2,4 -> overrun; hold in DRAIN
        run_case(1, 2, 2, 0, 0, 10);
        check("b_nreq",   n_req, 2);
        check("b_req2",   req_at[2], 4);
        check("b_ovr",    int'(bus.overrun), 1);
        check("b_busy",   int'(bus.busy), 1);
        check("b_flag",   int'(bus.flag), 0);
        check("b_nodone", done_cyc, 0);
        @(negedge clk);
        bus.sample_ack = 1'b1;
        #1;
        check("b_ackbusy", int'(bus.busy), 1);
        @(negedge clk);
        bus.sample_ack = 1'b0;
        #1;
        check("b_done",    int'(bus.done), 1);
        check("b_ovrhold", int'(bus.overrun), 1);
        @(negedge clk); #1;
        check("b_idle",    int'(bus.busy), 0);
        check("b_donelo",  int'(bus.done), 0);

        // dh=3, ns=10, stop the cycle after 2nd req (reqs 6,12; stop 13)
        run_case(3, 10, 1, 2, 0, 40);
        check("c_nreq",   n_req, 2);
        check("c_req2",   req_at[2], 12);
        check("c_stop",   stop_cyc, 13);
        check("c_flag",   int'(bus.flag), 0);
        check("c_busy",   int'(bus.busy), 0);
        check("c_nodone", done_cyc, 0);
        check("c_cnt",    int'(bus.sample_cnt), 2);
        check("c_ovrclr", int'(bus.overrun), 0);

        // Invalid starts are ignored
        @(negedge clk);
        bus.start = 1'b1; bus.div_half = 8'd4; bus.num_samples = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("d_ns0_busy", int'(bus.busy), 0);
        check("d_ns0_cnt",  int'(bus.sample_cnt), 2);
        @(negedge clk);
        bus.start = 1'b1; bus.div_half = 8'd0; bus.num_samples = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("d_dh0_busy", int'(bus.busy), 0);
        check("d_dh0_flag", int'(bus.flag), 0);

        // Reset mid-RUN with overrun set (dh=1, ns=5, no ack, reqs 2,4,6)
        run_case(1, 5, 2, 0, 0, 6);
        check("f_ovr",    int'(bus.overrun), 1);
        check("f_busy",   int'(bus.busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("f_rflag", int'(bus.flag), 0);
        check("f_rbusy", int'(bus.busy), 0);
        check("f_rovr",  int'(bus.overrun), 0);
        check("f_rcnt",  int'(bus.sample_cnt), 0);
        check("f_rreq",  int'(bus.sample_req), 0);
        check("f_rdone", int'(bus.done), 0);

        // Fresh run after reset: dh=2, ns=1 -> req 4, DRAIN 5 (acked), DONE 6
        run_case(2, 1, 1, 0, 0, 20);
        check("g_req1", req_at[1], 4);
        check("g_done", done_cyc, 6);
        check("g_cnt",  int'(bus.sample_cnt), 1);
        check("g_ovr",  int'(bus.overrun), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
